// File: rtl/cmp_pkg.sv
// Shared definitions for the shared-comparator arbiter:
// result flag encodings and the requester-ID width helper.
package cmp_pkg;

    // Result flags are ordered {lesser, greater, equal}
    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_GT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    // ID width for n requesters, never narrower than one bit
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans req upward from ptr,
// wrapping at NREQ-1, and grants the first set bit when en is high.
// Ports: req/en/ptr in; one-hot gnt and binary gnt_id out.
import cmp_pkg::*;

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic found;
    int   idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Shares one unsigned magnitude comparator between NREQ lanes.
// Ports: clk, rst (sync, active-high); req/op_a/op_b lane inputs;
// gnt one-hot accept; res_* registered result with valid/ready;
// cmp_count saturating count of accepted compares.
import cmp_pkg::*;

module cmp_share_arbiter #(
    parameter int N    = 5,
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ),
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] op_a,
    input  logic [NREQ*N-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDW-1:0]    res_id,
    output logic              res_lesser,
    output logic              res_greater,
    output logic              res_equal,
    output logic [CNTW-1:0]   cmp_count
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_id;
    logic           accept_en;
    logic           grant;
    logic [N-1:0]   sel_a;
    logic [N-1:0]   sel_b;
    logic [2:0]     cmp_res;
    logic [2:0]     flags;

    // Output slot is free when empty or being drained this cycle;
    // reset also blocks grants so nothing is accepted on that edge
    assign accept_en = (!res_valid || res_ready) && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req),
        .en     (accept_en),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign grant = |gnt;

    // Operands are only captured for the granted lane
    assign sel_a = op_a[int'(gnt_id)*N +: N];
    assign sel_b = op_b[int'(gnt_id)*N +: N];

    always_comb begin
        cmp_res = CMP_EQ;
        if (sel_a < sel_b) begin
            cmp_res = CMP_LT;
        end else if (sel_a > sel_b) begin
            cmp_res = CMP_GT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            flags     <= 3'b000;
            ptr       <= '0;
            cmp_count <= '0;
        end else if (grant) begin
            res_valid <= 1'b1;
            res_id    <= gnt_id;
            flags     <= cmp_res;
            ptr       <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            if (cmp_count != '1) begin
                cmp_count <= cmp_count + 1'b1;
            end
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign res_lesser  = flags[2];
    assign res_greater = flags[1];
    assign res_equal   = flags[0];

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter: directed scenarios then
// randomized traffic against a behavioural round-robin model.
module tb_cmp_share_arbiter;

    localparam int N    = 5;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] op_a;
    logic [NREQ*N-1:0] op_b;
    logic [NREQ-1:0]   gnt;
    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic              res_lesser;
    logic              res_greater;
    logic              res_equal;
    logic [CNTW-1:0]   cmp_count;

    cmp_share_arbiter #(
        .N    (N),
        .NREQ (NREQ),
        .IDW  (IDW),
        .CNTW (CNTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .gnt         (gnt),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_lesser  (res_lesser),
        .res_greater (res_greater),
        .res_equal   (res_equal),
        .cmp_count   (cmp_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model state
    bit       m_valid;
    int       m_id;
    bit [2:0] m_flags;
    int       m_cnt;
    int       m_ptr;
    int       last_g;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        if (rst) return -1;
        if (m_valid && !res_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int l;
            l = (m_ptr + k) % NREQ;
            if (req[l]) return l;
        end
        return -1;
    endfunction

    task automatic set_lane(input int i, input int a, input int b);
        op_a[i*N +: N] = N'(a);
        op_b[i*N +: N] = N'(b);
    endtask

    // Called at posedge+1: checks mid-cycle, then advances the model
    task automatic cycle();
        int g;
        int a;
        int b;
        logic [NREQ-1:0] eg;
        @(negedge clk);
        g  = exp_grant();
        eg = (g < 0) ? '0 : NREQ'(1 << g);
        chk("gnt", gnt, eg);
        chk("res_valid", res_valid, m_valid);
        chk("res_id", res_id, m_id);
        chk("flags", {res_lesser, res_greater, res_equal}, m_flags);
        chk("cmp_count", cmp_count, m_cnt);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_id = 0; m_flags = 0; m_cnt = 0; m_ptr = 0;
        end else if (g >= 0) begin
            a = int'(op_a[g*N +: N]);
            b = int'(op_b[g*N +: N]);
            m_flags = (a < b) ? 3'b100 : (a > b) ? 3'b010 : 3'b001;
            m_valid = 1;
            m_id    = g;
            m_ptr   = (g + 1) % NREQ;
            if (m_cnt < CMAX) m_cnt++;
        end else if (res_ready) begin
            m_valid = 0;
        end
        last_g = g;
        #1;
    endtask

    initial begin
        m_valid = 0; m_id = 0; m_flags = 0; m_cnt = 0; m_ptr = 0;
        last_g = -1;
        rst = 1'b1; req = '0; res_ready = 1'b1;
        op_a = '0; op_b = '0;
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Single request after reset
        set_lane(0, 7, 7);
        req = 4'b0001;
        cycle();
        req = 4'b0000;
        chk("t1_valid", res_valid, 1);
        chk("t1_id", res_id, 0);
        chk("t1_flags", {res_lesser, res_greater, res_equal}, 3'b001);
        chk("t1_count", cmp_count, 1);

        // Round-robin rotation from ptr=0
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_lane(0, 1, 2);
        set_lane(1, 9, 9);
        set_lane(2, 3, 20);
        set_lane(3, 31, 0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t2_order", last_g, k % 4);
            if (k == 2) chk("t2_lt", {res_lesser, res_greater, res_equal}, 3'b100);
            if (k == 3) chk("t2_gt", {res_lesser, res_greater, res_equal}, 3'b010);
        end

        // Backpressure holds result and pointer
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t3_nogrant", last_g, -1);
            chk("t3_hold_id", res_id, 0);
        end
        res_ready = 1'b1;
        cycle();
        chk("t3_resume", last_g, 1);

        // Wrap and skip: move ptr to 3, then req=0101
        req = 4'b0100;
        cycle();
        chk("t4_pre", last_g, 2);
        req = 4'b0101;
        cycle();
        chk("t4_wrap", last_g, 0);
        cycle();
        chk("t4_skip", last_g, 2);

        // Counter saturation
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req = 4'b0001;
        for (int k = 0; k < 20; k++) cycle();
        chk("t5_sat", cmp_count, 15);

        // Mid-stream reset
        req = 4'b1111;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_valid", res_valid, 0);
        chk("t6_count", cmp_count, 0);
        cycle();
        chk("t6_first", last_g, 0);

        // Randomized traffic
        req = '0;
        for (int t = 0; t < 400; t++) begin
            if (last_g >= 0) req[last_g] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom % 2 == 0) begin
                        int a;
                        int b;
                        a = int'($urandom % 32);
                        b = ($urandom % 4 == 0) ? a : int'($urandom % 32);
                        set_lane(i, a, b);
                        req[i] = 1'b1;
                    end
                end else if ($urandom % 16 == 0) begin
                    req[i] = 1'b0;
                end
            end
            res_ready = ($urandom % 4 != 0);
            rst = ($urandom % 60 == 0);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
